// File: rtl/stopwatch_display.sv
// stopwatch_display: minutes counter with adjust mode driving a blinking MM.SS multiplexed 7-segment display.
// Define LEADING_ZERO_BLANK_EN to blank the minutes tens digit while minutes < 10.
module stopwatch_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV = 25000000,
  parameter int ADJ_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sec_in,
  input  logic       sec_wrap,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  output logic [5:0] min_out,
  output logic       min_wrap,
  output logic [7:0] seg,
  output logic [3:0] an
);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int AW = $clog2(ADJ_DIV + 1);
  logic [RW-1:0] ref_cnt;
  logic [BW-1:0] blk_cnt;
  logic [AW-1:0] adj_cnt;
  logic [1:0] idx;
  logic wrap_q, phase, ref_tc, blk_tc, adj_tc, inc;
  logic [5:0] sec_c, dval;
  logic [3:0] dig;
  logic [7:0] seg_d;
  function automatic logic [7:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      default: return 8'h90;
    endcase
  endfunction
  always_comb begin
    ref_tc = ref_cnt == RW'(REFRESH_DIV - 1);
    blk_tc = blk_cnt == BW'(BLINK_DIV - 1);
    adj_tc = adj_cnt == AW'(ADJ_DIV - 1);
    inc = adj ? (!sel && adj_tc) : (sec_wrap && !wrap_q && !pause);
    sec_c = sec_in > 6'd59 ? 6'd59 : sec_in;
    dval = idx[1] ? min_out : sec_c;
    dig = idx[0] ? 4'(dval / 6'd10) : 4'(dval % 6'd10);
    // idx2 carries the MM.SS separator dot
    seg_d = enc(dig) & (idx == 2'd2 ? 8'h7F : 8'hFF);
    if (!phase && (sel ? !idx[1] : idx[1])) seg_d = 8'hFF;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 2'd3 && min_out < 6'd10) seg_d = 8'hFF;
`endif
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wrap_q <= 1'b0;
      ref_cnt <= '0;
      blk_cnt <= '0;
      adj_cnt <= '0;
      idx <= '0;
      phase <= 1'b1;
      min_out <= '0;
      min_wrap <= 1'b0;
      an <= 4'hF;
      seg <= 8'hFF;
    end else begin
      wrap_q <= sec_wrap;
      ref_cnt <= ref_tc ? '0 : ref_cnt + 1'b1;
      idx <= idx + 2'(ref_tc);
      adj_cnt <= (!adj || sel || adj_tc) ? '0 : adj_cnt + 1'b1;
      blk_cnt <= (!adj || blk_tc) ? '0 : blk_cnt + 1'b1;
      phase <= !adj || (phase ^ blk_tc);
      if (inc) min_out <= min_out == 6'd59 ? '0 : min_out + 1'b1;
      min_wrap <= inc && min_out == 6'd59;
      an <= ~(4'b0001 << idx);
      seg <= seg_d;
    end
endmodule

// File: tb/tb_stopwatch_display.sv
// tb_stopwatch_display: table-driven and randomized checks of stopwatch_display against an arithmetic reference model.
module tb_stopwatch_display;
  localparam int REF = 4, BLK = 8, ADJ = 16;
  logic clk = 1'b0, rst = 1'b0, sec_wrap = 1'b0, pause = 1'b0, adj = 1'b0, sel = 1'b0;
  logic [5:0] sec_in = '0, min_out;
  logic min_wrap;
  logic [7:0] seg;
  logic [3:0] an;
  int n_cmp = 0, n_bad = 0;
  bit go = 0;
  stopwatch_display #(.REFRESH_DIV(REF), .BLINK_DIV(BLK), .ADJ_DIV(ADJ)) dut (
    .clk(clk), .rst(rst), .sec_in(sec_in), .sec_wrap(sec_wrap), .pause(pause),
    .adj(adj), .sel(sel), .min_out(min_out), .min_wrap(min_wrap), .seg(seg), .an(an)
  );
  always #5 clk = ~clk;
  logic [7:0] enc_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  function automatic logic [7:0] exp_seg(int i, int s, int mn, bit sl, bit ph);
    int v, d;
    logic [7:0] r;
    v = i >= 2 ? mn : (s > 59 ? 59 : s);
    d = (i % 2 == 1) ? v / 10 : v % 10;
    r = enc_tab[d];
    if (i == 2) r[7] = 1'b0;
    if (!ph && (sl ? i < 2 : i >= 2)) r = 8'hFF;
`ifdef LEADING_ZERO_BLANK_EN
    if (i == 3 && mn < 10) r = 8'hFF;
`endif
    return r;
  endfunction
  // Reference model: slot from elapsed cycles, blink/adjust from how long adj has been held.
  int n, arun, srun, m_min, srun_n;
  bit m_wrap, prev_sw, m_inc;
  logic [3:0] e_an;
  logic [7:0] e_seg;
  always_comb begin
    srun_n = (adj && !sel) ? srun + 1 : 0;
    m_inc = adj ? (srun_n != 0 && srun_n % ADJ == 0) : (sec_wrap && !prev_sw && !pause);
  end
  always @(posedge clk or negedge rst)
    if (!rst) begin
      n <= 0; arun <= 0; srun <= 0; m_min <= 0; m_wrap <= 0; prev_sw <= 0;
      e_an <= 4'hF; e_seg <= 8'hFF;
    end else begin
      e_an <= ~(4'b0001 << ((n / REF) % 4));
      e_seg <= exp_seg((n / REF) % 4, int'(sec_in), m_min, sel, arun == 0 || (arun / BLK) % 2 == 0);
      srun <= srun_n;
      m_wrap <= m_inc && m_min == 59;
      if (m_inc) m_min <= (m_min + 1) % 60;
      arun <= adj ? arun + 1 : 0;
      prev_sw <= sec_wrap;
      n <= n + 1;
    end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (go) begin
      check("model min_out", 32'(min_out), m_min);
      check("model min_wrap", 32'(min_wrap), 32'(m_wrap));
      check("model an", 32'(an), 32'(e_an));
      check("model seg", 32'(seg), 32'(e_seg));
    end
  task automatic wait_an(input logic [3:0] t, input string nm);
    int k = 0;
    while (an !== t && k < 12) begin
      @(negedge clk);
      k++;
    end
    check(nm, 32'(an), 32'(t));
  endtask
  task automatic cycles(input int c);
    repeat (c) @(negedge clk);
  endtask
  typedef struct { logic [5:0] sec; logic [7:0] s0, s1; } dig_t;
  typedef struct { logic [3:0] an; logic [7:0] seg; } scan_t;
  dig_t dt[7];
  scan_t sc[4];
  int wcnt;
  initial begin
    dt[0] = '{6'd0, 8'hC0, 8'hC0};
    dt[1] = '{6'd9, 8'h90, 8'hC0};
    dt[2] = '{6'd10, 8'hC0, 8'hF9};
    dt[3] = '{6'd42, 8'hA4, 8'h99};
    dt[4] = '{6'd59, 8'h90, 8'h92};
    dt[5] = '{6'd60, 8'h90, 8'h92};
    dt[6] = '{6'd63, 8'h90, 8'h92};
    sc[0] = '{4'b1110, 8'hA4};
    sc[1] = '{4'b1101, 8'h99};
    sc[2] = '{4'b1011, 8'h78};
`ifdef LEADING_ZERO_BLANK_EN
    sc[3] = '{4'b0111, 8'hFF};
`else
    sc[3] = '{4'b0111, 8'hC0};
`endif
    cycles(2);
    check("reset min_out", 32'(min_out), 0);
    check("reset min_wrap", 32'(min_wrap), 0);
    check("reset an", 32'(an), 32'hF);
    check("reset seg", 32'(seg), 32'hFF);
    rst = 1'b1;
    go = 1;
    foreach (dt[i]) begin
      sec_in = dt[i].sec;
      cycles(1);
      wait_an(4'b1110, "dig slot0");
      check("dig ones", 32'(seg), 32'(dt[i].s0));
      wait_an(4'b1101, "dig slot1");
      check("dig tens", 32'(seg), 32'(dt[i].s1));
    end
    adj = 1'b1;
    cycles(7 * ADJ);
    adj = 1'b0;
    check("adjust to 7", 32'(min_out), 7);
    sec_in = 6'd42;
    cycles(2);
    foreach (sc[i]) begin
      wait_an(sc[i].an, "scan an");
      check("scan seg", 32'(seg), 32'(sc[i].seg));
    end
    pause = 1'b1;
    repeat (3) begin
      sec_wrap = 1'b1;
      cycles(1);
      sec_wrap = 1'b0;
      cycles(1);
    end
    check("pause holds", 32'(min_out), 7);
    pause = 1'b0;
    sec_wrap = 1'b1;
    cycles(10);
    sec_wrap = 1'b0;
    cycles(1);
    check("level counts once", 32'(min_out), 8);
    adj = 1'b1;
    cycles(50 * ADJ);
    check("adjust to 58", 32'(min_out), 58);
    wcnt = 0;
    repeat (3 * ADJ) begin
      sec_wrap = 1'($urandom_range(0, 1));
      cycles(1);
      if (min_wrap) wcnt++;
    end
    sec_wrap = 1'b0;
    adj = 1'b0;
    check("adjust wraps to 1", 32'(min_out), 1);
    check("adjust wrap pulses", 32'(wcnt), 1);
    cycles(1);
    adj = 1'b1;
    cycles(58 * ADJ);
    adj = 1'b0;
    check("adjust to 59", 32'(min_out), 59);
    sec_wrap = 1'b1;
    cycles(1);
    sec_wrap = 1'b0;
    check("wrap min_out", 32'(min_out), 0);
    check("wrap pulse", 32'(min_wrap), 1);
    cycles(1);
    check("wrap pulse ends", 32'(min_wrap), 0);
    adj = 1'b1;
    sel = 1'b1;
    cycles(5 * BLK);
    check("sel1 freezes", 32'(min_out), 0);
    adj = 1'b0;
    sel = 1'b0;
    cycles(2 * REF * 4);
    sec_wrap = 1'b1;
    cycles(1);
    sec_wrap = 1'b0;
    cycles(3);
    check("pre-reset min", 32'(min_out), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async reset min_out", 32'(min_out), 0);
    check("async reset an", 32'(an), 32'hF);
    check("async reset seg", 32'(seg), 32'hFF);
    @(negedge clk);
    rst = 1'b1;
    cycles(1);
    check("scan restarts idx0", 32'(an), 32'b1110);
    for (int i = 0; i < 3000; i++) begin
      sec_in = 6'($urandom_range(0, 63));
      sec_wrap = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 7) == 0) pause = ~pause;
      if ($urandom_range(0, 39) == 0) adj = ~adj;
      if ($urandom_range(0, 29) == 0) sel = ~sel;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
      end
      cycles(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
